// File: rtl/uart_rx_frame_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_sampler_if
// Description : Serial-side inputs and received-word outputs of the UART
//               frame sampler, bundled for connection to the RX buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_sampler_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 sample_tick;
    logic                 rx_in;
    logic                 start_bit_detected;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    // The frame engine produces the received word and its status.
    modport master (
        input  sample_tick,
        input  rx_in,
        input  start_bit_detected,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output sample_tick,
        output rx_in,
        output start_bit_detected,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_sampler
// Description : UART receive frame engine: mid-bit start qualification,
//               LSB-first data, optional parity and stop-bit sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    uart_rx_frame_sampler_if.master bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] c_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          c_ODD       = (PARITY_ODD != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_mismatch;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    logic [2:0]           w_state_nxt;
    logic [TW-1:0]        w_tick_nxt;
    logic [BW-1:0]        w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_mismatch_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_perr_nxt;
    logic                 w_ferr_nxt;
    logic                 w_tick_mid;
    logic                 w_tick_last;

    assign w_tick_mid  = (r_tick_cnt == c_TICK_MID);
    assign w_tick_last = (r_tick_cnt == c_TICK_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = r_tick_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_mismatch_nxt = r_par_mismatch;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_perr_nxt     = r_perr;
        w_ferr_nxt     = r_ferr;

        case (r_state)
            c_IDLE: begin
                if (bus.sample_tick && bus.start_bit_detected) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = c_START;
                end
            end

            // A start bit that is high again by mid-bit is treated as a glitch.
            c_START: begin
                if (bus.sample_tick) begin
                    if (w_tick_mid) begin
                        if (bus.rx_in) begin
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_tick_nxt     = '0;
                            w_bit_nxt      = '0;
                            w_mismatch_nxt = 1'b0;
                            w_state_nxt    = c_DATA;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            c_DATA: begin
                if (bus.sample_tick) begin
                    if (w_tick_last) begin
                        w_shift_nxt = {bus.rx_in, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_nxt = (PARITY_EN != 0) ? c_PARITY : c_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            c_PARITY: begin
                if (bus.sample_tick) begin
                    if (w_tick_last) begin
                        w_mismatch_nxt = bus.rx_in ^ (^r_shift) ^ c_ODD;
                        w_tick_nxt     = '0;
                        w_state_nxt    = c_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            // Frame completes at mid-stop-bit so the next start edge is not missed.
            c_STOP: begin
                if (bus.sample_tick) begin
                    if (w_tick_last) begin
                        w_data_nxt  = r_shift;
                        w_perr_nxt  = r_par_mismatch;
                        w_ferr_nxt  = ~bus.rx_in;
                        w_valid_nxt = 1'b1;
                        w_tick_nxt  = '0;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_IDLE;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_par_mismatch <= 1'b0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_perr         <= 1'b0;
            r_ferr         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tick_cnt     <= w_tick_nxt;
            r_bit_cnt      <= w_bit_nxt;
            r_shift        <= w_shift_nxt;
            r_par_mismatch <= w_mismatch_nxt;
            r_data         <= w_data_nxt;
            r_valid        <= w_valid_nxt;
            r_perr         <= w_perr_nxt;
            r_ferr         <= w_ferr_nxt;
            r_busy         <= (w_state_nxt != c_IDLE);
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_sampler
// Description : Directed self-checking bench for uart_rx_frame_sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_sampler;

    logic clk;
    logic rst_n;
    logic tick;
    int   checks;
    int   errors;

    uart_rx_frame_sampler_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_frame_sampler_if #(.DATA_BITS(7)) bus_b ();

    uart_rx_frame_sampler #(
        .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    uart_rx_frame_sampler #(
        .OVERSAMPLE(16), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    // The start detector is modelled directly from the line level.
    assign bus_a.start_bit_detected = ~bus_a.rx_in;
    assign bus_b.start_bit_detected = ~bus_b.rx_in;
    assign bus_a.sample_tick        = tick;
    assign bus_b.sample_tick        = tick;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    end

    int       nva, nvb, busy_cyc_a;
    logic [7:0] log_data_a [16];
    logic       log_perr_a [16];
    logic       log_ferr_a [16];
    logic [6:0] log_data_b [16];
    logic       log_ferr_b [16];

    initial begin
        nva = 0;
        nvb = 0;
        busy_cyc_a = 0;
        forever begin
            @(negedge clk);
            if (bus_a.rx_valid === 1'b1) begin
                if (nva < 16) begin
                    log_data_a[nva] = bus_a.rx_data;
                    log_perr_a[nva] = bus_a.parity_err;
                    log_ferr_a[nva] = bus_a.frame_err;
                end
                nva++;
            end
            if (bus_b.rx_valid === 1'b1) begin
                if (nvb < 16) begin
                    log_data_b[nvb] = bus_b.rx_data;
                    log_ferr_b[nvb] = bus_b.frame_err;
                end
                nvb++;
            end
            if (bus_a.busy === 1'b1) busy_cyc_a++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic p, input logic s);
        return {5'b0, s, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic s);
        return {7'b0, s, d, 1'b0};
    endfunction

    task automatic send_a(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.rx_in = f[i];
            wait_ticks(16);
        end
        bus_a.rx_in = 1'b1;
    endtask

    task automatic send_b(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus_b.rx_in = f[i];
            wait_ticks(16);
        end
        bus_b.rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.rx_in = 1'b1;
        bus_b.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus_a.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", bus_a.rx_data); end
        checks++; if (bus_a.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus_a.rx_valid); end
        checks++; if (bus_a.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", bus_a.parity_err); end
        checks++; if (bus_a.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus_a.frame_err); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
        rst_n = 1'b1;
        wait_ticks(4);
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", bus_b.busy); end
    endtask

    task automatic test_basic();
        int v0, b0;
        v0 = nva;
        b0 = busy_cyc_a;
        send_a(frame_a(8'hA5, 1'b0, 1'b1), 11);
        wait_ticks(4);
        checks++; if (nva !== v0 + 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected %0d", nva - v0, 1); end
        checks++; if (log_data_a[v0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", log_data_a[v0]); end
        checks++; if (log_perr_a[v0] !== 1'b0) begin errors++; $display("FAIL basic_parity_err: got %b expected 0", log_perr_a[v0]); end
        checks++; if (log_ferr_a[v0] !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", log_ferr_a[v0]); end
        checks++; if (busy_cyc_a - b0 !== 336) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 336", busy_cyc_a - b0); end
        checks++; if (bus_a.rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data_hold: got %h expected a5", bus_a.rx_data); end
        checks++; if (bus_a.rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_low: got %b expected 0", bus_a.rx_valid); end
    endtask

    task automatic test_parity_err();
        int v0;
        v0 = nva;
        send_a(frame_a(8'h3C, 1'b1, 1'b1), 11);
        wait_ticks(4);
        checks++; if (nva !== v0 + 1) begin errors++; $display("FAIL parity_valid_count: got %0d expected 1", nva - v0); end
        checks++; if (log_data_a[v0] !== 8'h3C) begin errors++; $display("FAIL parity_data: got %h expected 3c", log_data_a[v0]); end
        checks++; if (log_perr_a[v0] !== 1'b1) begin errors++; $display("FAIL parity_err_flag: got %b expected 1", log_perr_a[v0]); end
        checks++; if (log_ferr_a[v0] !== 1'b0) begin errors++; $display("FAIL parity_frame_err: got %b expected 0", log_ferr_a[v0]); end
        checks++; if (bus_a.parity_err !== 1'b1) begin errors++; $display("FAIL parity_err_hold: got %b expected 1", bus_a.parity_err); end
    endtask

    task automatic test_frame_err();
        int v0;
        v0 = nva;
        send_a(frame_a(8'h55, 1'b0, 1'b0), 11);
        wait_ticks(20);
        checks++; if (nva !== v0 + 1) begin errors++; $display("FAIL frame_valid_count: got %0d expected 1", nva - v0); end
        checks++; if (log_data_a[v0] !== 8'h55) begin errors++; $display("FAIL frame_data: got %h expected 55", log_data_a[v0]); end
        checks++; if (log_ferr_a[v0] !== 1'b1) begin errors++; $display("FAIL frame_err_flag: got %b expected 1", log_ferr_a[v0]); end
        checks++; if (log_perr_a[v0] !== 1'b0) begin errors++; $display("FAIL frame_parity_err: got %b expected 0", log_perr_a[v0]); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b expected 0", bus_a.busy); end
    endtask

    task automatic test_glitch();
        int v0, b0;
        v0 = nva;
        b0 = busy_cyc_a;
        bus_a.rx_in = 1'b0;
        wait_ticks(3);
        bus_a.rx_in = 1'b1;
        wait_ticks(12);
        checks++; if (nva !== v0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected 0", nva - v0); end
        checks++; if (busy_cyc_a - b0 !== 16) begin errors++; $display("FAIL glitch_busy_cycles: got %0d expected 16", busy_cyc_a - b0); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", bus_a.busy); end
        send_a(frame_a(8'h81, 1'b0, 1'b1), 11);
        wait_ticks(4);
        checks++; if (nva !== v0 + 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", nva - v0); end
        checks++; if (log_data_a[v0] !== 8'h81) begin errors++; $display("FAIL glitch_next_data: got %h expected 81", log_data_a[v0]); end
        checks++; if ({log_perr_a[v0], log_ferr_a[v0]} !== 2'b00) begin errors++; $display("FAIL glitch_next_errs: got %b expected 00", {log_perr_a[v0], log_ferr_a[v0]}); end
    endtask

    task automatic test_back_to_back();
        int v0, w0;
        v0 = nva;
        send_a(frame_a(8'h00, 1'b0, 1'b1), 11);
        send_a(frame_a(8'hFF, 1'b0, 1'b1), 11);
        wait_ticks(4);
        checks++; if (nva !== v0 + 2) begin errors++; $display("FAIL b2b_a_count: got %0d expected 2", nva - v0); end
        checks++; if (log_data_a[v0] !== 8'h00) begin errors++; $display("FAIL b2b_a_first: got %h expected 00", log_data_a[v0]); end
        checks++; if (log_data_a[v0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_a_second: got %h expected ff", log_data_a[v0+1]); end
        checks++; if ({log_perr_a[v0+1], log_ferr_a[v0+1]} !== 2'b00) begin errors++; $display("FAIL b2b_a_errs: got %b expected 00", {log_perr_a[v0+1], log_ferr_a[v0+1]}); end
        w0 = nvb;
        send_b(frame_b(7'h00, 1'b1), 9);
        send_b(frame_b(7'h7F, 1'b1), 9);
        wait_ticks(4);
        checks++; if (nvb !== w0 + 2) begin errors++; $display("FAIL b2b_b_count: got %0d expected 2", nvb - w0); end
        checks++; if (log_data_b[w0] !== 7'h00) begin errors++; $display("FAIL b2b_b_first: got %h expected 00", log_data_b[w0]); end
        checks++; if (log_data_b[w0+1] !== 7'h7F) begin errors++; $display("FAIL b2b_b_second: got %h expected 7f", log_data_b[w0+1]); end
        checks++; if (log_ferr_b[w0+1] !== 1'b0) begin errors++; $display("FAIL b2b_b_frame_err: got %b expected 0", log_ferr_b[w0+1]); end
        checks++; if (bus_b.parity_err !== 1'b0) begin errors++; $display("FAIL b2b_b_parity_err: got %b expected 0", bus_b.parity_err); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        v0 = nva;
        bus_a.rx_in = 1'b0;
        wait_ticks(16);
        bus_a.rx_in = 1'b1;
        wait_ticks(20);
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus_a.busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %h expected 00", bus_a.rx_data); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus_a.busy); end
        checks++; if (bus_a.parity_err !== 1'b0) begin errors++; $display("FAIL midrst_parity_err: got %b expected 0", bus_a.parity_err); end
        checks++; if (bus_b.rx_data !== 7'h00) begin errors++; $display("FAIL midrst_rx_data_b: got %h expected 00", bus_b.rx_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(200);
        checks++; if (nva !== v0) begin errors++; $display("FAIL midrst_no_valid: got %0d expected 0", nva - v0); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", bus_a.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
